// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts sig_in rising edges over GATE_TICKS clk_in cycles.
// Optional deglitch stage is compiled in with `define FREQ_METER_FILTER_EN.
module freq_meter #(
    parameter int FREQ_IN    = 100_000_000,
    parameter int GATE_TICKS = FREQ_IN,
    parameter int CNT_W      = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sig_in,
    input  logic             en,
    input  logic             freq_ack,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow,
    output logic             overrun,
    output logic             busy
);

    localparam int               GW        = $clog2(GATE_TICKS);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (GATE_TICKS < 2 || FREQ_IN < 1) begin : g_bad_params
        $error("freq_meter: GATE_TICKS must be >= 2 and FREQ_IN positive");
    end

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync_pipe;
    logic             rise;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_sum;
    logic             ovf_int, ovf_sum;
    logic             gate_done, cnt_clr, publish;

    // ---------------- input synchronizer / edge detect ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[0], sig_in};
    end

`ifdef FREQ_METER_FILTER_EN
    logic [1:0] samp_hist;
    logic       filt_q, all_hi, all_lo;

    // Level moves only once three consecutive synchronized samples agree;
    // the rise is taken on the cycle the filtered level goes high.
    assign all_hi = sync_pipe[1] & (&samp_hist);
    assign all_lo = ~(sync_pipe[1] | (|samp_hist));
    assign rise   = all_hi & ~filt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            samp_hist <= '0;
            filt_q    <= 1'b0;
        end else begin
            samp_hist <= {samp_hist[0], sync_pipe[1]};
            if (all_hi)      filt_q <= 1'b1;
            else if (all_lo) filt_q <= 1'b0;
        end
    end
`else
    logic prev_q;

    assign rise = sync_pipe[1] & ~prev_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) prev_q <= 1'b0;
        else        prev_q <= sync_pipe[1];
    end
`endif

    // ---------------- FSM ----------------
    assign gate_done = (state == GATE) && (gate_cnt == GATE_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = GATE;
            GATE: begin
                if (gate_done)  state_nxt = en ? GATE : IDLE;
                else if (!en)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters clear both on entry from IDLE and on a back-to-back restart.
    always_comb begin
        busy    = (state == GATE);
        publish = gate_done;
        cnt_clr = (state_nxt == GATE) && ((state == IDLE) || gate_done);
    end

    // ---------------- window counters ----------------
    always_comb begin
        edge_sum = edge_cnt;
        ovf_sum  = ovf_int;
        if (rise) begin
            if (edge_cnt == CNT_MAX) ovf_sum  = 1'b1;
            else                     edge_sum = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || cnt_clr) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_sum;
            ovf_int  <= ovf_sum;
        end
    end

    // ---------------- result / handshake ----------------
    // A publish always wins over a same-cycle ack; overrun only flags a lost result.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            overrun    <= 1'b0;
        end else if (publish) begin
            freq_out   <= edge_sum;
            overflow   <= ovf_sum;
            freq_valid <= 1'b1;
            if (freq_valid && !freq_ack) overrun <= 1'b1;
        end else if (freq_valid && freq_ack) begin
            freq_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
